imm_gen_pipe: RTL and testbench

Pipelined, parametrised RISC-V immediate generator between fetch/decode and the execute operand muxes. Decodes the full 7-bit opcode (plus funct3 for SYSTEM) and emits a sign- or zero-extended XLEN-wide immediate, a format code and an illegal flag. Results leave through a registered valid/ready stage with a skid buffer, so the block absorbs downstream stalls without combinational ready paths. An opaque tag (e.g. PC or ROB index) travels alongside each instruction.

---
 rtl/imm_gen_pkg.sv | 37 +++
 rtl/imm_decode.sv | 94 +++++++++
 rtl/imm_gen_pipe.sv | 109 ++++++++++
 tb/tb_imm_gen_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and encoding constants for the RISC-V immediate generator.
package imm_gen_pkg;

    // Format code emitted alongside each immediate.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_ILL  = 3'd7
    } fmt_e;

    // Major opcodes, inst[6:0].
    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_OP         = 7'b0110011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_OP_32      = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

    // SYSTEM funct3 values (funct3[2]=1 selects the CSR-immediate forms).
    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> immediate, format, illegal.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i_type;
    logic [XLEN-1:0] imm_s_type;
    logic [XLEN-1:0] imm_b_type;
    logic [XLEN-1:0] imm_u_type;
    logic [XLEN-1:0] imm_j_type;
    logic [XLEN-1:0] imm_z_type;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Sized casts of signed operands sign-extend to XLEN, so one expression serves RV32 and RV64.
    assign imm_i_type = XLEN'($signed(inst_i[31:20]));
    assign imm_s_type = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b_type = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u_type = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j_type = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_z_type = XLEN'(inst_i[19:15]);

    // Opcode decode; JALR keeps its LSB because the target adder clears it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fmt_o = FMT_ILL;
        imm_o = '0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_JALR: begin
                fmt_o = FMT_I;
                imm_o = imm_i_type;
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm_o = imm_s_type;
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = imm_b_type;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = imm_u_type;
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm_o = imm_j_type;
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    fmt_o = FMT_Z;
                    imm_o = imm_z_type;
                end else if (funct3 == F3_CSRRW || funct3 == F3_CSRRS || funct3 == F3_CSRRC) begin
                    fmt_o = FMT_I;
                    imm_o = imm_i_type;
                end else begin
                    fmt_o = FMT_NONE;
                end
            end
            OPC_OP: begin
                fmt_o = FMT_NONE;
            end
            OPC_OP_IMM_32: begin
                if (IS_RV64) begin
                    fmt_o = FMT_I;
                    imm_o = imm_i_type;
                end
            end
            OPC_OP_32: begin
                if (IS_RV64) begin
                    fmt_o = FMT_NONE;
                end
            end
            default: begin
                fmt_o = FMT_ILL;
            end
        endcase
    end

    assign illegal_o = (fmt_o == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on input, registered output stage with skid buffer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          in_entry;
    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            in_fire;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign in_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};

    // Ready comes from a register; it is only masked while reset is held.
    assign in_ready = in_ready_q && !reset;
    assign in_fire  = in_valid && in_ready;

    // Next-state for the output and skid registers; skid drains first to keep FIFO order.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset; reset outranks flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            // NOTE: payload registers are reset too, because out_imm/out_fmt/out_tag must read zero after reset.
            out_q        <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};
            skid_q       <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on RV32 and RV64 instances, then stall/flush/reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [7:0]  in_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_LUI  = 32'h800000B7;
    localparam logic [31:0] I_JALR = 32'h00108067;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stalled(input string name, input logic [7:0] tag, input logic [31:0] imm);
        check({name, "_valid"}, 64'(out_valid32), 64'd1);
        check({name, "_tag"}, 64'(out_tag32), 64'(tag));
        check({name, "_imm"}, 64'(out_imm32), 64'(imm));
        check({name, "_in_ready"}, 64'(in_ready32), 64'd0);
    endtask

    initial begin
        //            inst           imm32          fmt32 imm64                   fmt64
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 3'd1}; // ADDI -1
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 3'd3}; // BEQ -4
        vecs[2]  = '{32'h0000006F, 32'h00000000, 3'd5, 64'h00000000_00000000, 3'd5}; // JAL 0
        vecs[3]  = '{32'h00108067, 32'h00000001, 3'd1, 64'h00000000_00000001, 3'd1}; // JALR +1
        vecs[4]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF_80000000, 3'd4}; // LUI
        vecs[5]  = '{32'h0010009B, 32'h00000000, 3'd7, 64'h00000000_00000001, 3'd1}; // ADDIW
        vecs[6]  = '{32'h3002D073, 32'h00000005, 3'd6, 64'h00000000_00000005, 3'd6}; // CSRRWI
        vecs[7]  = '{32'h00000000, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd7}; // all zero
        vecs[8]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 64'hFFFFFFFF_FFFFFFF8, 3'd2}; // SW -8
        vecs[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 64'h00000000_00000000, 3'd0}; // ADD
        vecs[10] = '{32'h12345097, 32'h12345000, 3'd4, 64'h00000000_12345000, 3'd4}; // AUIPC
        vecs[11] = '{32'h00000073, 32'h00000000, 3'd0, 64'h00000000_00000000, 3'd0}; // ECALL
        vecs[12] = '{32'hC0002573, 32'hFFFFFC00, 3'd1, 64'hFFFFFFFF_FFFFFC00, 3'd1}; // CSRRS
        vecs[13] = '{32'h002080BB, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd0}; // ADDW
        vecs[14] = '{32'h00000001, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd7}; // compressed
        vecs[15] = '{32'hFFFFF06F, 32'hFFFFFFFE, 3'd5, 64'hFFFFFFFF_FFFFFFFE, 3'd5}; // JAL -2
        vecs[16] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 64'h00000000_000000FF, 3'd1}; // FENCE

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inst   = '0;
        in_tag    = '0;

        // Reset values while reset is held.
        tick();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd0);
        check("rst_imm", 64'(out_imm32), 64'd0);
        check("rst_fmt", 64'(out_fmt32), 64'd0);
        check("rst_illegal", 64'(out_illegal32), 64'd0);
        check("rst_tag", 64'(out_tag32), 64'd0);
        check("rst_imm64", out_imm64, 64'd0);

        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready32), 64'd1);
        check("post_rst_out_valid", 64'(out_valid32), 64'd0);

        // Decode table, streamed back to back.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_inst   = vecs[i].inst;
            in_tag    = 8'(i + 1);
            tick();
            check($sformatf("v%0d_valid", i), 64'(out_valid32), 64'd1);
            check($sformatf("v%0d_tag", i), 64'(out_tag32), 64'(i + 1));
            check($sformatf("v%0d_imm32", i), 64'(out_imm32), 64'(vecs[i].imm32));
            check($sformatf("v%0d_fmt32", i), 64'(out_fmt32), 64'(vecs[i].fmt32));
            check($sformatf("v%0d_ill32", i), 64'(out_illegal32), 64'(vecs[i].fmt32 == 3'd7));
            check($sformatf("v%0d_imm64", i), out_imm64, vecs[i].imm64);
            check($sformatf("v%0d_fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt64));
            check($sformatf("v%0d_ill64", i), 64'(out_illegal64), 64'(vecs[i].fmt64 == 3'd7));
            check($sformatf("v%0d_in_ready", i), 64'(in_ready32), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid32), 64'd0);

        // Backpressure: tag1 in out, tag2 in skid, tag3 held upstream.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = I_ADDI;
        in_tag    = 8'd1;
        tick();
        check("bp1_valid", 64'(out_valid32), 64'd1);
        check("bp1_tag", 64'(out_tag32), 64'd1);
        check("bp1_in_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        in_inst = I_LUI;
        in_tag  = 8'd2;
        tick();
        check_stalled("bp2", 8'd1, 32'hFFFFFFFF);
        @(negedge clk);
        in_inst = I_JALR;
        in_tag  = 8'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_stalled($sformatf("bp_hold%0d", k), 8'd1, 32'hFFFFFFFF);
            check($sformatf("bp_hold%0d_fmt", k), 64'(out_fmt32), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        check("bp_out2_valid", 64'(out_valid32), 64'd1);
        check("bp_out2_tag", 64'(out_tag32), 64'd2);
        check("bp_out2_imm", 64'(out_imm32), 64'h80000000);
        check("bp_out2_fmt", 64'(out_fmt32), 64'd4);
        check("bp_out2_in_ready", 64'(in_ready32), 64'd1);
        tick();
        check("bp_out3_valid", 64'(out_valid32), 64'd1);
        check("bp_out3_tag", 64'(out_tag32), 64'd3);
        check("bp_out3_imm", 64'(out_imm32), 64'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Flush during a stall discards both held entries.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = I_ADDI;
        in_tag    = 8'd1;
        tick();
        @(negedge clk);
        in_tag = 8'd2;
        tick();
        check("fl_pre_in_ready", 64'(in_ready32), 64'd0);
        @(negedge clk);
        in_tag = 8'd3;
        flush  = 1'b1;
        tick();
        check("fl_valid", 64'(out_valid32), 64'd0);
        check("fl_in_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_after%0d_valid", k), 64'(out_valid32), 64'd0);
        end

        // An input presented in the flush cycle is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        in_tag   = 8'd9;
        flush    = 1'b1;
        tick();
        check("fl_drop_valid", 64'(out_valid32), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl_drop_after", 64'(out_valid32), 64'd0);

        // Reset mid-stall returns every output to its reset value.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = I_ADDI;
        in_tag    = 8'd5;
        tick();
        @(negedge clk);
        in_tag = 8'd6;
        tick();
        check("mr_pre_valid", 64'(out_valid32), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("mr_valid", 64'(out_valid32), 64'd0);
        check("mr_imm", 64'(out_imm32), 64'd0);
        check("mr_fmt", 64'(out_fmt32), 64'd0);
        check("mr_illegal", 64'(out_illegal32), 64'd0);
        check("mr_tag", 64'(out_tag32), 64'd0);
        check("mr_in_ready", 64'(in_ready32), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mr_post_in_ready", 64'(in_ready32), 64'd1);
        check("mr_post_valid", 64'(out_valid32), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
